// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and geometry helper for the convolution engine.
package cnn_pkg;

   localparam int input_size_def      = 28;
   localparam int cnn_filter_size_def = 3;
   localparam int cnn_num_filters_def = 16;
   localparam int cnn_stride_def      = 2;
   localparam int data_w              = 32;
   localparam int acc_w               = 64;
   localparam int idx_w               = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic int out_size_f(input int in_sz, input int f_sz, input int st);
      return (in_sz - f_sz) / st + 1;
   endfunction

endpackage

// File: rtl/cnn_mac.sv
// Signed 32x32 multiply into a 64-bit accumulator; result is the saturated, ReLU'd running sum.
module cnn_mac
   import cnn_pkg::*;
(
   input  logic                     clk,
   input  logic                     rstb,
   input  logic                     en,
   input  logic                     clr,
   input  logic signed [data_w-1:0] pixel,
   input  logic signed [data_w-1:0] weight,
   output logic        [data_w-1:0] result
);

   logic signed [acc_w-1:0] prod_s;
   logic signed [acc_w-1:0] sum_s;
   logic signed [acc_w-1:0] acc_r;

   function automatic logic signed [data_w-1:0] sat32(input logic signed [acc_w-1:0] v);
      if (v > 64'sh0000_0000_7FFF_FFFF) begin
         return 32'sh7FFF_FFFF;
      end else if (v < 64'shFFFF_FFFF_8000_0000) begin
         return 32'sh8000_0000;
      end else begin
         return $signed(v[data_w-1:0]);
      end
   endfunction

   function automatic logic [data_w-1:0] relu32(input logic signed [data_w-1:0] v);
      if (v[data_w-1]) begin
         return 32'd0;
      end else begin
         return v;
      end
   endfunction

   // Sign-extend both operands so the low 64 bits of the product are the exact signed result.
   assign prod_s = {{(acc_w-data_w){pixel[data_w-1]}}, pixel} *
                   {{(acc_w-data_w){weight[data_w-1]}}, weight};
   assign sum_s  = acc_r + prod_s;
   assign result = relu32(sat32(sum_s));

   // Accumulator register
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         acc_r <= 64'sd0;
      end else if (clr) begin
         acc_r <= 64'sd0;
      end else if (en) begin
         acc_r <= sum_s;
      end else begin
         acc_r <= acc_r;
      end
   end

endmodule

// File: rtl/cnn_engine.sv
// Strided 2-D convolution engine: walks filter/row/col/tap, one MAC per cycle, one result per 10 cycles.
module cnn_engine
   import cnn_pkg::*;
#(
   parameter int input_size      = input_size_def,
   parameter int cnn_filter_size = cnn_filter_size_def,
   parameter int cnn_num_filters = cnn_num_filters_def,
   parameter int cnn_stride      = cnn_stride_def
)(
   input  logic                     clk,
   input  logic                     rstb,
   input  logic signed [data_w-1:0] input_data [input_size*input_size],
   input  logic signed [data_w-1:0] conv_filter_weight [cnn_num_filters][cnn_filter_size*cnn_filter_size],
   output logic                     out_valid,
   output logic        [idx_w-1:0]  out_filter,
   output logic        [idx_w-1:0]  out_row,
   output logic        [idx_w-1:0]  out_col,
   output logic        [data_w-1:0] out_data,
   output logic                     done
);

   localparam int out_size = out_size_f(input_size, cnn_filter_size, cnn_stride);
   localparam int pix_w    = $clog2(input_size * input_size);
   localparam int tap_w    = $clog2(cnn_filter_size * cnn_filter_size);

   state_t             state_r, state_nxt_s;
   logic [idx_w-1:0]   filter_r, row_r, col_r, ky_r, kx_r;
   logic [pix_w-1:0]   pix_addr_s;
   logic [tap_w-1:0]   tap_addr_s;
   logic               last_tap_s, last_res_s, mac_en_s, mac_clr_s;
   logic [data_w-1:0]  mac_result_s;

   assign pix_addr_s = pix_w'((int'(row_r) * cnn_stride + int'(ky_r)) * input_size
                              + int'(col_r) * cnn_stride + int'(kx_r));
   assign tap_addr_s = tap_w'(int'(ky_r) * cnn_filter_size + int'(kx_r));

   assign last_tap_s = (ky_r == idx_w'(cnn_filter_size - 1)) && (kx_r == idx_w'(cnn_filter_size - 1));
   assign last_res_s = (filter_r == idx_w'(cnn_num_filters - 1)) &&
                       (row_r == idx_w'(out_size - 1)) && (col_r == idx_w'(out_size - 1));
   assign mac_en_s   = (state_r == MAC);
   assign mac_clr_s  = (state_r == EMIT);

   cnn_mac u_mac (
      .clk    (clk),
      .rstb   (rstb),
      .en     (mac_en_s),
      .clr    (mac_clr_s),
      .pixel  (input_data[pix_addr_s]),
      .weight (conv_filter_weight[filter_r][tap_addr_s]),
      .result (mac_result_s)
   );

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: state_nxt_s = MAC;
         MAC: begin
            if (last_tap_s) begin
               state_nxt_s = EMIT;
            end else begin
               state_nxt_s = MAC;
            end
         end
         EMIT: begin
            if (last_res_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = MAC;
            end
         end
         DONE:    state_nxt_s = DONE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Tap/position counters and output registers; outputs load on the final tap so they appear on EMIT entry.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         filter_r   <= 4'd0;
         row_r      <= 4'd0;
         col_r      <= 4'd0;
         ky_r       <= 4'd0;
         kx_r       <= 4'd0;
         out_valid  <= 1'b0;
         out_filter <= 4'd0;
         out_row    <= 4'd0;
         out_col    <= 4'd0;
         out_data   <= 32'd0;
         done       <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state_r)
            MAC: begin
               if (last_tap_s) begin
                  ky_r       <= 4'd0;
                  kx_r       <= 4'd0;
                  out_valid  <= 1'b1;
                  out_filter <= filter_r;
                  out_row    <= row_r;
                  out_col    <= col_r;
                  out_data   <= mac_result_s;
                  if (last_res_s) begin
                     done <= 1'b1;
                  end
               end else if (kx_r == idx_w'(cnn_filter_size - 1)) begin
                  kx_r <= 4'd0;
                  ky_r <= ky_r + 4'd1;
               end else begin
                  kx_r <= kx_r + 4'd1;
               end
            end
            EMIT: begin
               if (!last_res_s) begin
                  if (col_r == idx_w'(out_size - 1)) begin
                     col_r <= 4'd0;
                     if (row_r == idx_w'(out_size - 1)) begin
                        row_r    <= 4'd0;
                        filter_r <= filter_r + 4'd1;
                     end else begin
                        row_r <= row_r + 4'd1;
                     end
                  end else begin
                     col_r <= col_r + 4'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cnn_engine.sv
// Directed bench for cnn_engine: vector table of image/weight patterns with probes, plus full-run and abort sequences.
module tb_cnn_engine;

   localparam int isz   = 28;
   localparam int fsz   = 3;
   localparam int nf    = 16;
   localparam int st    = 2;
   localparam int osz   = (isz - fsz) / st + 1;
   localparam int taps  = fsz * fsz;
   localparam int total = nf * osz * osz;

   logic               clk = 1'b0;
   logic               rstb = 1'b1;
   logic signed [31:0] input_data [isz*isz];
   logic signed [31:0] conv_filter_weight [nf][taps];
   logic               out_valid;
   logic [3:0]         out_filter, out_row, out_col;
   logic [31:0]        out_data;
   logic               done;

   int checks = 0;
   int passes = 0;

   typedef struct {
      int          pin;
      int          pw;
      int          nres;
      int          pf;
      int          pr;
      int          pc;
      logic [31:0] pexp;
   } vec_t;

   vec_t vecs [10];

   cnn_engine #(
      .input_size      (isz),
      .cnn_filter_size (fsz),
      .cnn_num_filters (nf),
      .cnn_stride      (st)
   ) dut (
      .clk                (clk),
      .rstb               (rstb),
      .input_data         (input_data),
      .conv_filter_weight (conv_filter_weight),
      .out_valid          (out_valid),
      .out_filter         (out_filter),
      .out_row            (out_row),
      .out_col            (out_col),
      .out_data           (out_data),
      .done               (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint outs();
      return longint'({out_valid, done, out_filter, out_row, out_col, out_data});
   endfunction

   // Reference: direct convolution with 64-bit sum, clamp, then ReLU.
   function automatic logic [31:0] model(input int f, input int r, input int c);
      longint s = 0;
      logic [9:0] pa;
      logic [3:0] ta;
      for (int ky = 0; ky < fsz; ky++) begin
         for (int kx = 0; kx < fsz; kx++) begin
            pa = 10'((r * st + ky) * isz + c * st + kx);
            ta = 4'(ky * fsz + kx);
            s += longint'(input_data[pa]) * longint'(conv_filter_weight[4'(f)][ta]);
         end
      end
      if (s < 0) return 32'd0;
      if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
      return s[31:0];
   endfunction

   task automatic load(input int pin, input int pw);
      for (int i = 0; i < isz * isz; i++) begin
         case (pin)
            0:       input_data[10'(i)] = 32'sd1;
            1:       input_data[10'(i)] = 32'(i);
            2:       input_data[10'(i)] = 32'sh7FFF_FFFF;
            3:       input_data[10'(i)] = 32'sh8000_0000;
            4:       input_data[10'(i)] = 32'((i % 5) - 2);
            default: input_data[10'(i)] = 32'sd0;
         endcase
      end
      for (int f = 0; f < nf; f++) begin
         for (int k = 0; k < taps; k++) begin
            case (pw)
               0:       conv_filter_weight[4'(f)][4'(k)] = 32'sd1;
               1:       conv_filter_weight[4'(f)][4'(k)] = (k == 4) ? 32'sd1 : 32'sd0;
               2:       conv_filter_weight[4'(f)][4'(k)] = 32'shFFFF_FFFF;
               3:       conv_filter_weight[4'(f)][4'(k)] = 32'sd2;
               4:       conv_filter_weight[4'(f)][4'(k)] = 32'(k - 4 + f);
               default: conv_filter_weight[4'(f)][4'(k)] = 32'sd0;
            endcase
         end
      end
   endtask

   task automatic do_reset();
      rstb = 1'b1;
      #1;
      rstb = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", outs(), 64'd0);
      @(negedge clk);
      rstb = 1'b1;
   endtask

   // Steps from reset release, checking every result's timing, index and data, plus one probe.
   task automatic run_vec(input int pin, input int pw, input int nres, input int pf, input int pr,
                          input int pc, input logic [31:0] pexp, input bit full, input bit rst_first);
      int ef = 0, er = 0, ec = 0, edge_n = 0, seen = 0, done_edge = 0, budget;
      bit hit = 1'b0;
      if (rst_first) begin
         load(pin, pw);
         do_reset();
      end
      budget = nres * 10 + 50;
      while (seen < nres && edge_n < budget) begin
         @(posedge clk);
         #1;
         edge_n++;
         if (done && done_edge == 0) done_edge = edge_n;
         if (out_valid) begin
            seen++;
            chk("valid_edge", edge_n, seen * 10);
            chk("index", longint'({out_filter, out_row, out_col}), ef * 256 + er * 16 + ec);
            chk("data", out_data, model(ef, er, ec));
            if (ef == pf && er == pr && ec == pc) begin
               hit = 1'b1;
               chk("probe", out_data, pexp);
            end
            if (ec == osz - 1) begin
               ec = 0;
               if (er == osz - 1) begin
                  er = 0;
                  ef++;
               end else begin
                  er++;
               end
            end else begin
               ec++;
            end
         end
      end
      chk("result_count", seen, nres);
      chk("probe_hit", hit, 1);
      if (full) begin
         chk("done_edge", done_edge, total * 10);
         for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            chk("done_hold", outs(), longint'({1'b0, 1'b1, 4'd15, 4'd12, 4'd12, 32'd9}));
         end
      end else begin
         chk("done_low", done_edge, 0);
      end
   endtask

   initial begin
      int nv;
      vecs[0] = '{0, 0,  30, 0,  1,  5, 32'd9};
      vecs[1] = '{1, 1, 170, 0,  0,  0, 32'd29};
      vecs[2] = '{1, 1, 170, 0, 12, 12, 32'd725};
      vecs[3] = '{1, 1, 338, 1, 12, 12, 32'd725};
      vecs[4] = '{1, 1, 170, 0,  0,  1, 32'd31};
      vecs[5] = '{0, 2, 300, 0,  3,  4, 32'd0};
      vecs[6] = '{2, 3,  40, 0,  1,  1, 32'h7FFF_FFFF};
      vecs[7] = '{3, 0,  40, 0,  2,  2, 32'd0};
      vecs[8] = '{4, 4,  40, 0,  0,  0, 32'd10};
      vecs[9] = '{4, 4,  40, 0,  0,  1, 32'd0};

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i].pin, vecs[i].pw, vecs[i].nres, vecs[i].pf, vecs[i].pr, vecs[i].pc,
                 vecs[i].pexp, 1'b0, 1'b1);
      end

      // Full run to completion, then terminal-state hold.
      run_vec(0, 0, total, 15, 12, 12, 32'd9, 1'b1, 1'b1);

      // Mid-run abort at edge 500, then restart from (0,0,0).
      load(0, 0);
      do_reset();
      nv = 0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) nv++;
      end
      chk("pre_abort_valids", nv, 50);
      chk("pre_abort_data", out_data, 32'd9);
      rstb = 1'b0;
      #1;
      chk("abort_outputs", outs(), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("abort_hold", outs(), 64'd0);
      @(negedge clk);
      rstb = 1'b1;
      run_vec(0, 0, 5, 0, 0, 0, 32'd9, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
